trigger_probe: RTL and testbench

TRIGGER_PROBE -- requirements
Module: trigger_probe

---
 rtl/probe_pkg.sv | 23 ++
 rtl/probe_capture_ram.sv | 29 ++
 rtl/trigger_probe.sv | 134 +++++++++++++
 tb/tb_trigger_probe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/probe_pkg.sv
// Shared types and the trigger compare function for the trigger probe.
package probe_pkg;

    localparam int MAX_CH = 64;

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        WAIT,
        POST,
        DONE
    } state_t;

    // Masked-off channels are don't-care, so an all-zero mask always hits.
    function automatic logic is_match(
        input logic [MAX_CH-1:0] d,
        input logic [MAX_CH-1:0] m,
        input logic [MAX_CH-1:0] v
    );
        return ((d ^ v) & m) == '0;
    endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// Simple dual-port capture memory: synchronous write, registered read.
module probe_capture_ram #(
    parameter int W  = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/trigger_probe.sv
// Pre/post-trigger logic analyser probe with circular capture memory.
// Define PROBE_EDGE_TRIGGER_EN to add the triggerEdge input (edge match).
module trigger_probe
    import probe_pkg::*;
#(
    parameter int CHANNELS    = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int PRE_TRIGGER = 64
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  arm,
    input  logic                  sampleEn,
    input  logic [CHANNELS-1:0]   dataIn,
    input  logic [CHANNELS-1:0]   triggerMask,
    input  logic [CHANNELS-1:0]   triggerValue,
`ifdef PROBE_EDGE_TRIGGER_EN
    input  logic                  triggerEdge,
`endif
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    input  logic [DEPTH_LOG2-1:0] readAddr,
    output logic [CHANNELS-1:0]   readData
);

    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int POST_N = DEPTH - PRE_TRIGGER - 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam ptr_t PRE_P     = ptr_t'(PRE_TRIGGER);
    localparam ptr_t PRE_LAST  = ptr_t'(PRE_TRIGGER - 1);
    localparam ptr_t POST_LAST = ptr_t'(POST_N - 1);

    state_t state, nxt;
    ptr_t   wrPtr, cnt, trigAddr, rdAddr;
    logic   store, hit, fire, capturing;

    assign capturing = (state == PREFILL) || (state == WAIT) ||
                       (state == POST);
    assign store = sampleEn && !arm && capturing;

    assign hit = is_match(MAX_CH'(dataIn), MAX_CH'(triggerMask),
                          MAX_CH'(triggerValue));

`ifdef PROBE_EDGE_TRIGGER_EN
    logic prevMatch;

    assign fire = hit && (!triggerEdge || !prevMatch);

    // Tracks every stored sample, prefill included, so a level held
    // across the prefill window cannot look like a fresh edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            prevMatch <= 1'b0;
        else if (arm)
            prevMatch <= 1'b0;
        else if (store)
            prevMatch <= hit;
    end
`else
    assign fire = hit;
`endif

    always_comb begin
        nxt = state;
        if (arm) begin
            nxt = (PRE_TRIGGER == 0) ? WAIT : PREFILL;
        end else begin
            unique case (state)
                PREFILL:
                    if (sampleEn && cnt == PRE_LAST)
                        nxt = WAIT;
                WAIT:
                    if (sampleEn && fire)
                        nxt = (POST_N == 0) ? DONE : POST;
                POST:
                    if (sampleEn && cnt == POST_LAST)
                        nxt = DONE;
                default:
                    nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr    <= '0;
            cnt      <= '0;
            trigAddr <= '0;
        end else if (arm) begin
            wrPtr    <= '0;
            cnt      <= '0;
            trigAddr <= '0;
        end else if (store) begin
            wrPtr <= wrPtr + 1'b1;
            if (nxt != state || state == WAIT)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == WAIT && fire)
                trigAddr <= wrPtr;
        end
    end

    assign armed     = (state == PREFILL) || (state == WAIT);
    assign triggered = (state == POST) || (state == DONE);
    assign done      = (state == DONE);

    // Logical index PRE_TRIGGER lands on the trigger sample.
    assign rdAddr = trigAddr - PRE_P + readAddr;

    probe_capture_ram #(
        .W  (CHANNELS),
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .resetN (resetN),
        .we     (store),
        .waddr  (wrPtr),
        .wdata  (dataIn),
        .raddr  (rdAddr),
        .rdata  (readData)
    );

endmodule

// File: tb/tb_trigger_probe.sv
// Directed self-checking bench for trigger_probe (8 ch, 16 deep, 4 pre).
module tb_trigger_probe;
    import probe_pkg::*;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       arm = 1'b0;
    logic       sampleEn = 1'b0;
    logic [7:0] dataIn = '0;
    logic [7:0] triggerMask = 8'hFF;
    logic [7:0] triggerValue = '0;
    logic       armed, triggered, done;
    logic [3:0] readAddr = '0;
    logic [7:0] readData;
`ifdef PROBE_EDGE_TRIGGER_EN
    logic       triggerEdge = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    trigger_probe #(
        .CHANNELS    (8),
        .DEPTH_LOG2  (4),
        .PRE_TRIGGER (4)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .arm          (arm),
        .sampleEn     (sampleEn),
        .dataIn       (dataIn),
        .triggerMask  (triggerMask),
        .triggerValue (triggerValue),
`ifdef PROBE_EDGE_TRIGGER_EN
        .triggerEdge  (triggerEdge),
`endif
        .armed        (armed),
        .triggered    (triggered),
        .done         (done),
        .readAddr     (readAddr),
        .readData     (readData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_pulse(input logic se, input logic [7:0] d);
        arm = 1'b1;
        sampleEn = se;
        dataIn = d;
        tick();
        arm = 1'b0;
        sampleEn = 1'b0;
    endtask

    task automatic smp(input logic [7:0] d);
        dataIn = d;
        sampleEn = 1'b1;
        tick();
        sampleEn = 1'b0;
    endtask

    task automatic smp3(input logic [7:0] d);
        dataIn = d;
        sampleEn = 1'b1;
        tick();
        sampleEn = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd(input string tag, input int i, input logic [7:0] exp);
        readAddr = 4'(i);
        tick();
        chk(tag, 32'(readData), 32'(exp));
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_armed", 32'(armed), 0);
        chk("rst_trig", 32'(triggered), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(readData), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        resetN = 1'b1;
        tick();

        // basic capture
        triggerMask = 8'hFF;
        triggerValue = 8'h0A;
        arm_pulse(1'b0, 8'h00);
        chk("b_armed", 32'(armed), 1);
        for (int k = 0; k < 22; k++) begin
            smp(8'(k));
            if (k == 9)  chk("b_trig_pre", 32'(triggered), 0);
            if (k == 10) chk("b_trig", 32'(triggered), 1);
            if (k == 10) chk("b_armed_off", 32'(armed), 0);
            if (k == 20) chk("b_done_pre", 32'(done), 0);
        end
        chk("b_done", 32'(done), 1);
        smp(8'h99);
        for (int i = 0; i < 16; i++)
            rd("b_read", i, 8'(6 + i));

        // sampleEn gating, data held three cycles
        arm_pulse(1'b0, 8'h00);
        for (int k = 0; k < 22; k++) begin
            smp3(8'(k));
            if (k == 20) chk("g_done_pre", 32'(done), 0);
        end
        chk("g_done", 32'(done), 1);
        for (int i = 0; i < 16; i++)
            rd("g_read", i, 8'(6 + i));

        // prefill masking: first 0x02 falls in prefill
        triggerValue = 8'h02;
        arm_pulse(1'b0, 8'h00);
        for (int k = 0; k < 270; k++) begin
            smp(8'(k));
            if (k == 2)   chk("p_trig_prefill", 32'(triggered), 0);
            if (k == 257) chk("p_trig_pre", 32'(triggered), 0);
            if (k == 258) chk("p_trig", 32'(triggered), 1);
        end
        chk("p_done", 32'(done), 1);
        rd("p_read4", 4, 8'h02);
        rd("p_read0", 0, 8'hFE);
        rd("p_read15", 15, 8'h0D);

        // re-arm in POST; arm-cycle sample must be dropped
        triggerValue = 8'h2A;
        arm_pulse(1'b0, 8'h00);
        for (int k = 0; k < 14; k++)
            smp(8'(8'h20 + k));
        chk("r_trig_first", 32'(triggered), 1);
        arm_pulse(1'b1, 8'h55);
        chk("r_trig_drop", 32'(triggered), 0);
        chk("r_done_low", 32'(done), 0);
        chk("r_armed", 32'(armed), 1);
        triggerValue = 8'h8A;
        for (int k = 0; k < 22; k++)
            smp(8'(8'h80 + k));
        chk("r_done", 32'(done), 1);
        for (int i = 0; i < 16; i++)
            rd("r_read", i, 8'(8'h86 + i));

        // reset mid-POST
        triggerValue = 8'h0A;
        arm_pulse(1'b0, 8'h00);
        for (int k = 0; k < 13; k++)
            smp(8'(k));
        chk("x_trig", 32'(triggered), 1);
        resetN = 1'b0;
        tick();
        chk("x_armed", 32'(armed), 0);
        chk("x_trig_off", 32'(triggered), 0);
        chk("x_done", 32'(done), 0);
        chk("x_state", 32'(dut.state), 32'(IDLE));
        resetN = 1'b1;
        tick();
        for (int k = 13; k < 30; k++)
            smp(8'(k));
        chk("x_idle_done", 32'(done), 0);
        chk("x_idle_state", 32'(dut.state), 32'(IDLE));

`ifdef PROBE_EDGE_TRIGGER_EN
        // edge mode: a held level never fires, a 0->1 edge does
        triggerEdge = 1'b1;
        triggerValue = 8'h01;
        arm_pulse(1'b0, 8'h00);
        for (int k = 0; k < 20; k++)
            smp(8'h01);
        chk("e_level", 32'(triggered), 0);
        smp(8'h00);
        chk("e_zero", 32'(triggered), 0);
        smp(8'h01);
        chk("e_edge", 32'(triggered), 1);
        for (int k = 0; k < 11; k++)
            smp(8'h01);
        chk("e_done", 32'(done), 1);
        rd("e_read4", 4, 8'h01);
        rd("e_read3", 3, 8'h00);
        triggerEdge = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
